// File: rtl/formula_loader.sv
// Formula loader: streams clause coefficient words into the gain block's clause
// registers (auto-incrementing index, one-hot write strobe), then enables the
// loaded clauses and gain evaluation.
//
// Ports:
//   in_clk, in_reset              clock (rising edge), async active-high reset
//   in_start, in_number_of_clauses begin a load of N = min(count, C) clauses
//   in_clause_valid / out_clause_ready, in_clause_coefficients_*  word input
//   out_clause_coefficients_*, out_clause_index, out_clause_write  clause write port
//   out_enable, out_gain_enable   per-clause enables and gain evaluation enable
//   out_busy, out_done            status: loading/settling, one-cycle RUN-entry pulse
module formula_loader #(
    parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT     = 4,
    parameter int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT     = 2,
    parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX  = 1,
    parameter int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX  = 1,
    parameter int MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX           = 2
) (
    input  logic                                   in_clk,
    input  logic                                   in_reset,
    input  logic                                   in_start,
    input  logic [MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX:0] in_number_of_clauses,
    input  logic                                   in_clause_valid,
    output logic                                   out_clause_ready,
    input  logic [(2**MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX+1)*MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT-1:0]
                                                   in_clause_coefficients_integer,
    input  logic [MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT*(2**MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX)-1:0]
                                                   in_clause_coefficients_boolean,
    output logic [(2**MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX+1)*MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT-1:0]
                                                   out_clause_coefficients_integer,
    output logic [MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT*(2**MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX)-1:0]
                                                   out_clause_coefficients_boolean,
    output logic [MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX-1:0] out_clause_index,
    output logic [2**MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX-1:0] out_clause_write,
    output logic [2**MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX-1:0] out_enable,
    output logic                                   out_gain_enable,
    output logic                                   out_busy,
    output logic                                   out_done
);

    localparam int CI = MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX;
    localparam int C  = 2**CI;
    localparam int IW = (2**MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX+1)*MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT;
    localparam int BW = MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT*(2**MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX);

    localparam logic [CI:0] C_MAX = (CI+1)'(C);
    localparam logic [CI:0] ONE_N = (CI+1)'(1);
    localparam logic [C-1:0] ONE_HOT0 = C'(1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_RUN    = 2'd3;

    // Requests beyond the number of physical slots are clamped to C.
    function automatic logic [CI:0] clamp_count(input logic [CI:0] n);
        if (n > C_MAX) begin
            return C_MAX;
        end
        return n;
    endfunction

    // Thermometer mask with the low n bits set.
    function automatic logic [C-1:0] low_mask(input logic [CI:0] n);
        logic [C-1:0] m;
        m = '0;
        for (int i = 0; i < C; i++) begin
            m[i] = ((CI+1)'(i) < n);
        end
        return m;
    endfunction

    logic [1:0]    state_q, state_d;
    logic [CI-1:0] count_q, count_d;
    logic [CI:0]   num_q,   num_d;
    logic [IW-1:0] int_q,   int_d;
    logic [BW-1:0] bool_q,  bool_d;
    logic [CI-1:0] index_q, index_d;
    logic [C-1:0]  write_q, write_d;
    logic [C-1:0]  enable_q, enable_d;
    logic          gain_q,  gain_d;
    logic          done_q,  done_d;

    logic [CI:0]   start_n;
    logic          last_word;

    assign start_n   = clamp_count(in_number_of_clauses);
    assign last_word = ({1'b0, count_q} == (num_q - ONE_N));

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        num_d    = num_q;
        int_d    = int_q;
        bool_d   = bool_q;
        index_d  = index_q;
        enable_d = enable_q;
        gain_d   = gain_q;
        // Strobe and done are single-cycle events; they default low every cycle.
        write_d  = '0;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (in_start) begin
                    // A restart from RUN withdraws the previous enables at once.
                    enable_d = '0;
                    gain_d   = 1'b0;
                    num_d    = start_n;
                    count_d  = '0;
                    if (start_n != '0) begin
                        state_d = ST_LOAD;
                    end else begin
                        // Empty formula: go straight to RUN with no clauses enabled.
                        state_d = ST_RUN;
                        gain_d  = 1'b1;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                // Ready is high throughout LOAD, so valid alone marks a transfer.
                if (in_clause_valid) begin
                    int_d   = in_clause_coefficients_integer;
                    bool_d  = in_clause_coefficients_boolean;
                    index_d = count_q;
                    write_d = ONE_HOT0 << count_q;
                    count_d = count_q + 1'b1;
                    if (last_word) begin
                        state_d = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                // One quiet cycle so the final clause write lands before enabling.
                state_d  = ST_RUN;
                enable_d = low_mask(num_q);
                gain_d   = 1'b1;
                done_d   = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            num_q    <= '0;
            int_q    <= '0;
            bool_q   <= '0;
            index_q  <= '0;
            write_q  <= '0;
            enable_q <= '0;
            gain_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            num_q    <= num_d;
            int_q    <= int_d;
            bool_q   <= bool_d;
            index_q  <= index_d;
            write_q  <= write_d;
            enable_q <= enable_d;
            gain_q   <= gain_d;
            done_q   <= done_d;
        end
    end

    assign out_clause_ready                = (state_q == ST_LOAD);
    assign out_busy                        = (state_q == ST_LOAD) || (state_q == ST_SETTLE);
    assign out_clause_coefficients_integer = int_q;
    assign out_clause_coefficients_boolean = bool_q;
    assign out_clause_index                = index_q;
    assign out_clause_write                = write_q;
    assign out_enable                      = enable_q;
    assign out_gain_enable                 = gain_q;
    assign out_done                        = done_q;

    // The clause register file relies on never seeing two slots written at once.
    write_onehot_a: assert property (@(posedge in_clk) disable iff (in_reset) $onehot0(write_q));

endmodule

// File: tb/tb_formula_loader.sv
module tb_formula_loader;

    logic        in_clk = 1'b0;
    logic        in_reset;
    logic        in_start;
    logic [2:0]  in_number_of_clauses;
    logic        in_clause_valid;
    logic        out_clause_ready;
    logic [11:0] in_clause_coefficients_integer;
    logic [3:0]  in_clause_coefficients_boolean;
    logic [11:0] out_clause_coefficients_integer;
    logic [3:0]  out_clause_coefficients_boolean;
    logic [1:0]  out_clause_index;
    logic [3:0]  out_clause_write;
    logic [3:0]  out_enable;
    logic        out_gain_enable;
    logic        out_busy;
    logic        out_done;

    formula_loader dut (
        .in_clk                          (in_clk),
        .in_reset                        (in_reset),
        .in_start                        (in_start),
        .in_number_of_clauses            (in_number_of_clauses),
        .in_clause_valid                 (in_clause_valid),
        .out_clause_ready                (out_clause_ready),
        .in_clause_coefficients_integer  (in_clause_coefficients_integer),
        .in_clause_coefficients_boolean  (in_clause_coefficients_boolean),
        .out_clause_coefficients_integer (out_clause_coefficients_integer),
        .out_clause_coefficients_boolean (out_clause_coefficients_boolean),
        .out_clause_index                (out_clause_index),
        .out_clause_write                (out_clause_write),
        .out_enable                      (out_enable),
        .out_gain_enable                 (out_gain_enable),
        .out_busy                        (out_busy),
        .out_done                        (out_done)
    );

    always #5 in_clk = ~in_clk;

    typedef struct {
        logic [1:0]  idx;
        logic [11:0] iv;
        logic [3:0]  bv;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          errors  = 0;
    int          exp_slot;
    logic [11:0] last_int;
    logic [3:0]  last_bool;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every strobe must match the oldest accepted word.
    always @(negedge in_clk) begin
        if (!in_reset && out_clause_write != 4'b0000) begin
            if (sb.size() == 0) begin
                check("spurious_strobe", {28'd0, out_clause_write}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("strobe", {28'd0, out_clause_write}, 32'd1 << e.idx);
                check("index", {30'd0, out_clause_index}, {30'd0, e.idx});
                check("coef_int", {20'd0, out_clause_coefficients_integer}, {20'd0, e.iv});
                check("coef_bool", {28'd0, out_clause_coefficients_boolean}, {28'd0, e.bv});
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, {31'd0, out_clause_ready}, 32'd0);
        check({tag, "_write"}, {28'd0, out_clause_write}, 32'd0);
        check({tag, "_enable"}, {28'd0, out_enable}, 32'd0);
        check({tag, "_gain"}, {31'd0, out_gain_enable}, 32'd0);
        check({tag, "_busy"}, {31'd0, out_busy}, 32'd0);
        check({tag, "_done"}, {31'd0, out_done}, 32'd0);
        check({tag, "_int"}, {20'd0, out_clause_coefficients_integer}, 32'd0);
        check({tag, "_bool"}, {28'd0, out_clause_coefficients_boolean}, 32'd0);
        check({tag, "_index"}, {30'd0, out_clause_index}, 32'd0);
    endtask

    // Called #1 after a rising edge; returns #1 after the sampling edge.
    task automatic do_start(input logic [2:0] n);
        in_start = 1'b1;
        in_number_of_clauses = n;
        @(posedge in_clk);
        #1;
        in_start = 1'b0;
    endtask

    // Offers one word; returns #1 after the edge that accepted it.
    task automatic send_word(input logic [11:0] iv, input logic [3:0] bv);
        int n;
        bit ok;
        exp_t e;
        n  = 0;
        ok = 0;
        in_clause_valid = 1'b1;
        in_clause_coefficients_integer = iv;
        in_clause_coefficients_boolean = bv;
        while (!ok && n < 20) begin
            @(negedge in_clk);
            if (out_clause_ready) begin
                e.idx = exp_slot[1:0];
                e.iv  = iv;
                e.bv  = bv;
                sb.push_back(e);
                exp_slot++;
                last_int  = iv;
                last_bool = bv;
                ok = 1;
            end
            @(posedge in_clk);
            #1;
            n++;
        end
        if (!ok) check("send_timeout", 32'd0, 32'd1);
        in_clause_valid = 1'b0;
    endtask

    // Waits for the done pulse, checks the cycles taken and the RUN outputs.
    task automatic wait_run(input int exp_lat, input logic [3:0] exp_en);
        int n;
        n = 0;
        do begin
            @(negedge in_clk);
            n++;
        end while (!out_done && n < 20);
        check("done_seen", {31'd0, out_done}, 32'd1);
        check("run_latency", n, exp_lat);
        check("run_enable", {28'd0, out_enable}, {28'd0, exp_en});
        check("run_gain", {31'd0, out_gain_enable}, 32'd1);
        check("run_busy", {31'd0, out_busy}, 32'd0);
        check("run_ready", {31'd0, out_clause_ready}, 32'd0);
        if (exp_en != 4'b0000) begin
            check("hold_int", {20'd0, out_clause_coefficients_integer}, {20'd0, last_int});
            check("hold_bool", {28'd0, out_clause_coefficients_boolean}, {28'd0, last_bool});
        end
        @(negedge in_clk);
        check("done_single", {31'd0, out_done}, 32'd0);
        check("enable_hold", {28'd0, out_enable}, {28'd0, exp_en});
        @(posedge in_clk);
        #1;
    endtask

    task automatic load_random(input logic [2:0] req, input int words, input logic [3:0] exp_en);
        exp_slot = 0;
        do_start(req);
        for (int i = 0; i < words; i++) begin
            send_word(12'($urandom), 4'($urandom));
        end
        wait_run(2, exp_en);
    endtask

    initial begin
        in_reset = 1'b1;
        in_start = 1'b0;
        in_number_of_clauses = '0;
        in_clause_valid = 1'b0;
        in_clause_coefficients_integer = '0;
        in_clause_coefficients_boolean = '0;
        exp_slot = 0;
        last_int = '0;
        last_bool = '0;
        repeat (3) @(posedge in_clk);
        #1;
        check_all_zero("reset");
        in_reset = 1'b0;
        @(posedge in_clk);
        #1;

        // Four back-to-back words, then an exact SETTLE/RUN timing check.
        exp_slot = 0;
        do_start(3'd4);
        @(negedge in_clk);
        check("load_ready", {31'd0, out_clause_ready}, 32'd1);
        check("load_busy", {31'd0, out_busy}, 32'd1);
        @(posedge in_clk);
        #1;
        send_word(12'h411, 4'hF);
        send_word(12'h511, 4'hB);
        send_word(12'h611, 4'hB);
        send_word(12'h311, 4'hF);
        @(negedge in_clk);
        check("settle_busy", {31'd0, out_busy}, 32'd1);
        check("settle_ready", {31'd0, out_clause_ready}, 32'd0);
        check("settle_done", {31'd0, out_done}, 32'd0);
        check("settle_gain", {31'd0, out_gain_enable}, 32'd0);
        @(posedge in_clk);
        #1;
        wait_run(1, 4'b1111);

        // Gaps of two idle cycles between words; ready must stay high.
        exp_slot = 0;
        do_start(3'd4);
        for (int i = 0; i < 4; i++) begin
            send_word(12'($urandom), 4'($urandom));
            if (i < 3) begin
                repeat (2) begin
                    @(negedge in_clk);
                    check("gap_ready", {31'd0, out_clause_ready}, 32'd1);
                    @(posedge in_clk);
                    #1;
                end
            end
        end
        wait_run(2, 4'b1111);

        // Partial and clamped loads.
        load_random(3'd2, 2, 4'b0011);
        load_random(3'd7, 4, 4'b1111);

        // Empty formula straight to RUN.
        do_start(3'd0);
        wait_run(1, 4'b0000);

        // Reset in the middle of a load.
        exp_slot = 0;
        do_start(3'd4);
        send_word(12'h0A5, 4'h3);
        send_word(12'h15A, 4'hC);
        @(negedge in_clk);
        #2;
        in_reset = 1'b1;
        #1;
        check_all_zero("midreset");
        check("midreset_sb", sb.size(), 32'd0);
        @(posedge in_clk);
        #1;
        in_reset = 1'b0;
        repeat (2) begin
            @(negedge in_clk);
            check("postreset_busy", {31'd0, out_busy}, 32'd0);
            check("postreset_write", {28'd0, out_clause_write}, 32'd0);
        end
        @(posedge in_clk);
        #1;
        load_random(3'd4, 4, 4'b1111);

        // Restart from RUN with N=1; a start during LOAD is ignored.
        exp_slot = 0;
        do_start(3'd1);
        @(negedge in_clk);
        check("restart_enable", {28'd0, out_enable}, 32'd0);
        check("restart_gain", {31'd0, out_gain_enable}, 32'd0);
        check("restart_ready", {31'd0, out_clause_ready}, 32'd1);
        @(posedge in_clk);
        #1;
        do_start(3'd4);
        @(negedge in_clk);
        check("ignored_start_busy", {31'd0, out_busy}, 32'd1);
        check("ignored_start_enable", {28'd0, out_enable}, 32'd0);
        @(posedge in_clk);
        #1;
        send_word(12'h7C3, 4'h9);
        wait_run(2, 4'b0001);

        repeat (3) @(posedge in_clk);
        #1;
        check("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
